// File: rtl/upsample_x3.sv
// Integer-factor upsampler: 2-entry sample buffer feeding a phase counter that
// emits FACTOR output samples per input, zero-stuffed (MODE 0) or held (MODE 1).
module upsample_x3 #(
  parameter int DATA_W = 16,
  parameter int FACTOR = 3,
  parameter int MODE   = 0
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_first,
  output logic              o_out_last,
  output logic              o_overrun
);

  localparam logic [3:0] LAST_PHASE = 4'(FACTOR - 1);

  logic [DATA_W-1:0] r_mem [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [3:0]        r_phase;
  logic              r_overrun;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_last;
  logic              w_out_hs;
  logic              w_pop;
  logic              w_pass;
  logic [DATA_W-1:0] w_head;

  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = i_in_valid & w_in_ready;
  assign w_last      = (r_phase == LAST_PHASE);
  assign w_out_hs    = w_out_valid & i_out_ready;
  assign w_pop       = w_out_hs & w_last;
  assign w_head      = r_mem[r_rd_ptr];
  // Phase 0 always carries the sample; later phases only in hold mode.
  assign w_pass      = (MODE != 0) || (r_phase == 4'd0);

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = (w_out_valid && w_pass) ? w_head : '0;
  assign o_out_first = w_out_valid & (r_phase == 4'd0);
  assign o_out_last  = w_out_valid & w_last;
  assign o_overrun   = r_overrun;

  // Sample storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_phase   <= 4'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_out_hs) begin
        r_phase <= w_last ? 4'd0 : r_phase + 4'd1;
      end
      if (i_in_valid && !w_in_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/upsample_x3.md
# upsample_x3

Integer-factor upsampler for the DFE transmit path, running entirely on the fast clock. It accepts samples at the divided (slow) rate and emits FACTOR output samples per input sample, using zero-stuffing or sample-hold. It undoes the rate step set by the divide-by-3 clock divider, so slow-domain samples re-enter the fast-rate datapath. A 2-entry input buffer absorbs input/output handshake jitter.

## Interface
- DATA_W, 16, sample width in bits (two's complement, passed through unmodified).
- FACTOR, 3, upsampling factor; legal range 2..16.
- MODE, 0, 0 = zero-stuff (phases 1..FACTOR-1 output 0), 1 = hold (all phases repeat the sample).
- clk_in  input  1  fast clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_W  input sample.
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept; transfer when in_valid & in_ready at rising edge.
- out_data  output  DATA_W  output sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_first  output  1  high with phase 0 of each input sample.
- out_last  output  1  high with phase FACTOR-1 of each input sample.
- overrun  output  1  sticky; set when in_valid is high while in_ready is low; cleared only by reset.

## Operation
- Storage: 2-entry FIFO of DATA_W words (wr_ptr, rd_ptr, 2-bit count), plus a 4-bit phase counter.
- in_ready = (count != 2). Push on an input handshake.
- out_valid = (count != 0). Head entry drives the output.
- Per-phase output:
  - phase 0: out_data = head.
  - phase ≥1: out_data = head in MODE 1, 0 in MODE 0.
- On an output handshake:
  - phase != FACTOR-1: phase increments.
  - phase == FACTOR-1: phase returns to 0 and the head pops.
- out_first = out_valid & (phase == 0); out_last = out_valid & (phase == FACTOR-1).
- out_data is 0 whenever out_valid is low.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at count 1. Legal at count 2 only on the pop side; in_ready is already low, so no push occurs.
- Full with no pop: in_ready = 0. An asserted in_valid sets overrun; the sample is not stored.
- Stall (out_valid & !out_ready): phase, out_data, out_first and out_last hold stable.
- Pointer wrap: 1-bit pointers wrap 1→0 naturally.

## Timing
- Reset (rst_n low, asynchronous), all registers clear:
  - count = 0, phase = 0, pointers = 0, overrun = 0.
  - Outputs: out_valid = 0, out_data = 0, out_first = 0, out_last = 0, in_ready = 1.
  - Inputs are ignored while rst_n is low.
- Reset mid-sample: the partially emitted sample is discarded. After reset release, the first output is phase 0 of the next accepted input.
- Latency: a sample accepted at edge N is presented (out_valid = 1, phase 0) in the cycle after edge N. No combinational path from in_* to out_*.
- Throughput: with out_ready held high, one input per FACTOR cycles sustains back-to-back output with out_valid continuously high. Slower input gives out_valid gaps of exactly (input period − FACTOR) cycles.
- out_ready is used only in the pop/phase update; there is no combinational out_ready→in_ready path.

## Test plan
- Basic zero-stuff: MODE=0, FACTOR=3, inputs 0x0101, 0x0202, 0x0303, one every 3 cycles, out_ready = 1.
  - Output: 0x0101, 0, 0, 0x0202, 0, 0, 0x0303, 0, 0.
  - out_first on the 1st/4th/7th outputs, out_last on the 3rd/6th/9th; out_valid continuous after the first edge.
- Hold mode: MODE=1, FACTOR=3, input 0x8000 (negative).
  - Output 0x8000 three times, then out_valid = 0.
- Backpressure and overrun:
  - out_ready = 0, push 0x0011 and 0x0022 → in_ready drops after the 2nd push.
  - A 3rd in_valid (0x0033) sets overrun = 1 and is dropped.
  - Release out_ready → output 0x0011, 0, 0, 0x0022, 0, 0.
- Stall mid-sample: deassert out_ready at phase 1 for 5 cycles.
  - phase = 1, out_data = 0 and out_valid = 1 stay stable for all 5 cycles; the sequence then resumes at phase 2 with out_last = 1.
- Reset mid-operation: assert rst_n low at phase 1 with count = 2.
  - All outputs go to their reset values immediately, asynchronously; in_ready = 1 and overrun = 0 after release.
  - Next input 0x0055 emerges as phase 0 one cycle after its handshake.
- FACTOR=2 and FACTOR=16 builds, MODE=0:
  - Per input, exactly FACTOR outputs.
  - out_last on the FACTOR-th output; the phase counter wraps correctly at 15→0.
